// File: rtl/wavetable_note_stepper.sv
// Steps a wavetable phase on rising edges of the note clock picked by the pressed keys.
// Note changes and note-off are deferred to the wavetable cycle boundary so the output stays click-free.
module wavetable_note_stepper #(
  parameter int unsigned NUM_NOTES = 15,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_NOTES-1:0] CLOCK_ARRAY,
  input  logic [NUM_NOTES-1:0] keys,
  output logic [ADDR_W-1:0]    sample_addr,
  output logic                 sample_valid,
  output logic [3:0]           note_idx,
  output logic                 playing
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_NOTES-1:0] ca_s1_q, ca_s2_q, ca_prev_q;
  logic [NUM_NOTES-1:0] key_s1_q, key_s2_q;

  logic [ADDR_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [3:0]        note_q, note_d;
  logic [3:0]        pend_q, pend_d;

  logic [NUM_NOTES-1:0] tick;
  logic                 any_key;
  logic [3:0]           sel;
  logic                 tick_ev;
  logic                 boundary;

  // Every bit is synchronised all the time, so reselecting a note never sees a stale edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ca_s1_q   <= '0;
      ca_s2_q   <= '0;
      ca_prev_q <= '0;
      key_s1_q  <= '0;
      key_s2_q  <= '0;
    end else begin
      ca_s1_q   <= CLOCK_ARRAY;
      ca_s2_q   <= ca_s1_q;
      ca_prev_q <= ca_s2_q;
      key_s1_q  <= keys;
      key_s2_q  <= key_s1_q;
    end
  end

  assign tick    = ca_s2_q & ~ca_prev_q;
  assign any_key = |key_s2_q;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      if (key_s2_q[NUM_NOTES-1-i]) sel = 4'(NUM_NOTES-1-i);
    end
  end

  assign tick_ev  = enable & tick[note_q];
  assign boundary = tick_ev & (phase_q == '1);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      note_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      note_q  <= note_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    note_d  = note_q;
    pend_d  = pend_q;

    if (enable) begin
      if (state_q != ST_IDLE && tick_ev) begin
        addr_d  = phase_q;
        phase_d = phase_q + 1'b1;
        valid_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          phase_d = '0;
          if (any_key) begin
            note_d  = sel;
            pend_d  = sel;
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (any_key) pend_d = sel;
          if (!any_key) begin
            state_d = boundary ? ST_IDLE : ST_RELEASE;
          end else if (boundary) begin
            // A key change landing on the boundary itself bypasses the pending register.
            note_d = (sel == pend_q) ? pend_q : sel;
          end
        end
        ST_RELEASE: begin
          if (any_key) begin
            pend_d  = sel;
            state_d = ST_PLAY;
            if (boundary) note_d = sel;
          end else if (boundary) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign sample_addr  = addr_q;
  assign sample_valid = valid_q;
  assign note_idx     = note_q;
  assign playing      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wavetable_note_stepper.sv
// Directed bench for wavetable_note_stepper with ADDR_W=4 and free-running note clocks
// (bit n period 20+4n CLK cycles, driven on the falling CLK edge).
module tb_wavetable_note_stepper;

  logic        CLK;
  logic        reset;
  logic        enable;
  logic [14:0] CLOCK_ARRAY;
  logic [14:0] keys;
  logic [3:0]  sample_addr;
  logic        sample_valid;
  logic [3:0]  note_idx;
  logic        playing;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rise_at [15];
  int ca_cnt  [15];

  wavetable_note_stepper #(.NUM_NOTES(15), .ADDR_W(4)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .enable       (enable),
    .CLOCK_ARRAY  (CLOCK_ARRAY),
    .keys         (keys),
    .sample_addr  (sample_addr),
    .sample_valid (sample_valid),
    .note_idx     (note_idx),
    .playing      (playing)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // A rise applied at a falling edge is first sampled at the next rising edge, number cyc+1.
  initial begin
    CLOCK_ARRAY = '0;
    for (int n = 0; n < 15; n++) begin
      ca_cnt[n]  = 3 * n;
      rise_at[n] = 0;
    end
    forever begin
      @(negedge CLK);
      for (int n = 0; n < 15; n++) begin
        logic nb;
        ca_cnt[n] = (ca_cnt[n] + 1) % (20 + 4 * n);
        nb = (ca_cnt[n] < (10 + 2 * n));
        if (nb && !CLOCK_ARRAY[n]) rise_at[n] = cyc + 1;
        CLOCK_ARRAY[n] = nb;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic get_sample(input int note, output logic [3:0] a, output int lat);
    bit got;
    got = 1'b0;
    a   = '0;
    lat = -1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge CLK);
      #1;
      if (sample_valid) begin
        got = 1'b1;
        a   = sample_addr;
        lat = cyc - rise_at[note];
      end
    end
    check_eq("sample_arrives", 32'(got), 32'd1);
  endtask

  task automatic expect_samples(input int note, input int first, input int count);
    logic [3:0] a;
    int lat;
    for (int i = 0; i < count; i++) begin
      get_sample(note, a, lat);
      check_eq("addr", 32'(a), 32'((first + i) % 16));
      check_eq("latency", 32'(lat), 32'd2);
      check_eq("note_idx", 32'(note_idx), 32'(note));
      check_eq("playing", 32'(playing), 32'd1);
    end
  endtask

  task automatic count_valids(input int ncyc, output int nvalid);
    nvalid = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge CLK);
      #1;
      if (sample_valid) nvalid++;
    end
  endtask

  initial begin
    logic [3:0] a;
    int lat;
    int nv;

    reset  = 1'b1;
    enable = 1'b1;
    keys   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_valid", 32'(sample_valid), 32'd0);
    check_eq("rst_addr", 32'(sample_addr), 32'd0);
    check_eq("rst_note", 32'(note_idx), 32'd0);
    check_eq("rst_playing", 32'(playing), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // 1: single key, full cycle plus wrap
    keys = 15'h0008;
    expect_samples(3, 0, 17);

    // 2: lowest index wins; note 5 edges are ignored
    keys = 15'h0028;
    expect_samples(3, 1, 4);

    // 3: note change deferred to the boundary
    keys = 15'h0008;
    expect_samples(3, 5, 2);
    keys = 15'h0400;
    expect_samples(3, 7, 8);
    get_sample(3, a, lat);
    check_eq("chg_addr15", 32'(a), 32'd15);
    check_eq("chg_lat15", 32'(lat), 32'd2);
    check_eq("chg_note_at_boundary", 32'(note_idx), 32'd10);
    expect_samples(10, 0, 1);

    // 4a: release mid-cycle finishes the cycle in RELEASE
    expect_samples(10, 1, 9);
    keys = '0;
    expect_samples(10, 10, 5);
    get_sample(10, a, lat);
    check_eq("rel_addr15", 32'(a), 32'd15);
    check_eq("rel_playing_end", 32'(playing), 32'd0);
    count_valids(150, nv);
    check_eq("rel_idle_valids", 32'(nv), 32'd0);
    check_eq("rel_idle_playing", 32'(playing), 32'd0);

    // 4b: release landing on the boundary tick
    keys = 15'h0400;
    expect_samples(10, 0, 15);
    @(posedge CLOCK_ARRAY[10]);
    keys = '0;
    get_sample(10, a, lat);
    check_eq("bnd_addr15", 32'(a), 32'd15);
    check_eq("bnd_playing", 32'(playing), 32'd0);
    count_valids(100, nv);
    check_eq("bnd_idle_valids", 32'(nv), 32'd0);

    // 5: enable low freezes, lost edges, resume without skip
    keys = 15'h0001;
    expect_samples(0, 0, 3);
    enable = 1'b0;
    count_valids(100, nv);
    check_eq("frz_valids", 32'(nv), 32'd0);
    check_eq("frz_addr", 32'(sample_addr), 32'd2);
    check_eq("frz_playing", 32'(playing), 32'd1);
    enable = 1'b1;
    expect_samples(0, 3, 5);

    // 6: reset mid-note at addr 7
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    check_eq("midrst_playing", 32'(playing), 32'd0);
    check_eq("midrst_addr", 32'(sample_addr), 32'd0);
    check_eq("midrst_valid", 32'(sample_valid), 32'd0);
    check_eq("midrst_note", 32'(note_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
